// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory controller.
//   WORD_LSB     - lowest byte-address bit that forms the SRAM word address
//   MAX_ADDR_W   - widest word address a 32-bit byte address can carry
//   wbuf_entry_t - one posted store: {word address, data word}
// The entry address field is sized for the widest case. Narrower SRAMs
// store their word address zero-extended, so all entries compare uniformly.
package dmem_pkg;

  localparam int WORD_LSB   = 2;
  localparam int MAX_ADDR_W = 32 - WORD_LSB;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0]           data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: bundles the core data port and the SRAM port of the controller.
//   core_re/core_raddr/core_rdata      - load request and load data
//   core_we/core_waddr/core_wdata      - store request
//   core_stall                         - request not accepted, core holds it
//   wbuf_empty                         - no pending stores
//   sram_en/sram_we/sram_addr/
//   sram_wdata/sram_rdata              - single-port synchronous SRAM
// Modports:
//   slave  - the controller's view
//   master - the view of the surrounding core + SRAM
interface dmem_if #(
  parameter int ADDR_W = 14
);

  logic              core_re;
  logic [31:0]       core_raddr;
  logic [31:0]       core_rdata;
  logic              core_we;
  logic [31:0]       core_waddr;
  logic [31:0]       core_wdata;
  logic              core_stall;
  logic              wbuf_empty;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  core_re, core_raddr, core_we, core_waddr, core_wdata, sram_rdata,
    output core_rdata, core_stall, wbuf_empty,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output core_re, core_raddr, core_we, core_waddr, core_wdata, sram_rdata,
    input  core_rdata, core_stall, wbuf_empty,
           sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: posted write buffer (circular FIFO) with associative lookup.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push          - write push_entry at tail (caller guarantees !full)
//   pop           - retire head entry (caller guarantees !empty)
//   head_entry    - oldest buffered store
//   full, empty   - occupancy flags
//   lookup_addr   - word address to search for
//   hit, hit_data - youngest valid entry matching lookup_addr
// DEPTH must be a power of two so the pointers wrap naturally.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wbuf_entry_t           push_entry,
  input  logic                  pop,
  output wbuf_entry_t           head_entry,
  output logic                  full,
  output logic                  empty,
  input  logic [MAX_ADDR_W-1:0] lookup_addr,
  output logic                  hit,
  output logic [31:0]           hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wbuf_entry_t      mem_reg [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] ent_match;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign head_entry = mem_reg[head_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: validity is derived from head/count.
  always_ff @(posedge clk) begin
    if (push) mem_reg[tail_reg] <= push_entry;
  end

  // Per-slot match. A slot is valid when its age (distance from head) is
  // below count; the head slot being popped this cycle is still valid.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [PTR_W-1:0] age;
      assign age = PTR_W'(gi) - head_reg;
      assign ent_match[gi] = (CNT_W'(age) < count_reg) &&
                             (mem_reg[gi].addr == lookup_addr);
    end
  endgenerate

  // Walk slots oldest to youngest so the youngest match overrides.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (ent_match[head_reg + PTR_W'(a)]) begin
        hit      = 1'b1;
        hit_data = mem_reg[head_reg + PTR_W'(a)].data;
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: merges core loads and stores onto one single-port SRAM.
// Stores are posted into dmem_wbuf; loads win the SRAM port unless the
// buffer is full, and the buffer drains whenever the port is otherwise idle.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (discards buffered stores)
//   bus   - dmem_if.slave: core data port and SRAM port
// Build option:
//   DMEM_FWD_EN defined   - loads hitting buffered stores are forwarded
//                           from the buffer (registered, 1-cycle latency)
//   DMEM_FWD_EN undefined - such loads stall until the matching entries
//                           have drained, then read the SRAM
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = 14
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  logic [ADDR_W-1:0]     raddr_word;
  logic [ADDR_W-1:0]     waddr_word;
  logic [MAX_ADDR_W-1:0] lookup_addr;
  wbuf_entry_t           push_entry;
  wbuf_entry_t           head_entry;
  logic                  full;
  logic                  empty;
  logic                  lk_hit;
  logic [31:0]           lk_data;
  logic                  push;
  logic                  pop;
  logic                  read_ok;
  logic                  read_sram;
  logic                  stall;
  logic                  fwd_hit_q;
  logic [31:0]           fwd_data_q;
  logic                  unused_ok;

  assign raddr_word  = bus.core_raddr[ADDR_W+1:WORD_LSB];
  assign waddr_word  = bus.core_waddr[ADDR_W+1:WORD_LSB];
  assign lookup_addr = MAX_ADDR_W'(raddr_word);
  assign push_entry  = '{addr: MAX_ADDR_W'(waddr_word), data: bus.core_wdata};

  dmem_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head_entry  (head_entry),
    .full        (full),
    .empty       (empty),
    .lookup_addr (lookup_addr),
    .hit         (lk_hit),
    .hit_data    (lk_data)
  );

  // Port arbiter. A full buffer always drains, which also breaks any
  // potential deadlock with a store held behind it.
  always_comb begin
`ifdef DMEM_FWD_EN
    read_ok   = bus.core_re && !full;
    // A forwarded load leaves the port free for a drain.
    read_sram = read_ok && !lk_hit;
`else
    read_ok   = bus.core_re && !full && !lk_hit;
    read_sram = read_ok;
`endif
    pop   = !empty && !read_sram;
    stall = (bus.core_re && !read_ok) || (bus.core_we && full);
    // A stalled cycle accepts nothing: the core re-presents both requests.
    push  = bus.core_we && !stall;

    bus.core_stall = stall;
    bus.sram_en    = read_sram || pop;
    bus.sram_we    = pop;
    bus.sram_addr  = pop ? head_entry.addr[ADDR_W-1:0] : raddr_word;
    bus.sram_wdata = head_entry.data;
  end

`ifdef DMEM_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q <= read_ok && lk_hit;
      if (read_ok && lk_hit) fwd_data_q <= lk_data;
    end
  end
  assign unused_ok = ^{bus.core_raddr, bus.core_waddr, head_entry.addr};
`else
  assign fwd_hit_q  = 1'b0;
  assign fwd_data_q = '0;
  assign unused_ok  = ^{bus.core_raddr, bus.core_waddr, head_entry.addr, lk_data};
`endif

  assign bus.core_rdata = fwd_hit_q ? fwd_data_q : bus.sram_rdata;
  assign bus.wbuf_empty = empty;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl (WBUF_DEPTH=4, ADDR_W=14).
// Directed load/store vectors carry hand-computed expected load data; the
// driver queues expected loads and expected SRAM writes at issue time, and
// two monitors pop and compare whenever the DUT returns load data or
// performs an SRAM write. Works with or without DMEM_FWD_EN.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;
`ifdef DMEM_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_ctrl #(
    .WBUF_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous single-port SRAM model, read data one cycle after access.
  logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = 32'h0;
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
      else             bus.sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]        rd_q [$];
  logic [ADDR_W+31:0] wr_q [$];
  bit  rd_pend = 1'b0;
  int  last_stalls;
  bit  last_rd_port;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load-data monitor: an accept seen at negedge N yields data at negedge N+1.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else                  check("load_data", bus.core_rdata, rd_q.pop_front());
      end
      rd_pend = rst_n && bus.core_re && !bus.core_stall;
    end
  end

  // SRAM-write monitor: writes must match stores in program order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.sram_en && bus.sram_we) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else check("sram_write", {18'b0, bus.sram_addr, bus.sram_wdata}, {18'b0, wr_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request cycle (load and/or store) and hold it until accepted.
  task automatic op(input bit re, input logic [31:0] ra, input logic [31:0] rexp,
                    input bit we, input logic [31:0] wa, input logic [31:0] wd);
    int stalls = 0;
    bit s;
    bus.core_re    = re;
    bus.core_raddr = ra;
    bus.core_we    = we;
    bus.core_waddr = wa;
    bus.core_wdata = wd;
    if (re) rd_q.push_back(rexp);
    if (we) wr_q.push_back({wa[ADDR_W+1:2], wd});
    forever begin
      @(negedge clk);
      s = bus.core_stall;
      last_rd_port = bus.sram_en && !bus.sram_we;
      @(posedge clk);
      #1;
      if (!s) break;
      stalls++;
      if (stalls > 40) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    bus.core_re = 1'b0;
    bus.core_we = 1'b0;
    last_stalls = stalls;
    $display("op re=%0d raddr=%h we=%0d waddr=%h wdata=%h stalls=%0d",
             re, ra, we, wa, wd, stalls);
  endtask

  initial begin
    bus.core_re    = 1'b0;
    bus.core_raddr = '0;
    bus.core_we    = 1'b0;
    bus.core_waddr = '0;
    bus.core_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wbuf_empty", bus.wbuf_empty, 1);
    check("rst_sram_en",    bus.sram_en,    0);
    check("rst_sram_we",    bus.sram_we,    0);
    check("rst_core_stall", bus.core_stall, 0);
    rst_n = 1'b1;
    idle(1);

    // Store then immediate load of the same word.
    op(0, 0, 0, 1, 32'h100, 32'hDEADBEEF);
    op(1, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    check("hit_stalls",    last_stalls,  FWD ? 0 : 1);
    check("hit_sram_read", last_rd_port, FWD ? 0 : 1);
    idle(2);

    // Two stores to one word kept pending by loads; youngest must win.
    op(1, 32'h300, 32'h0, 1, 32'h200, 32'h11);
    op(1, 32'h304, 32'h0, 1, 32'h200, 32'h22);
    op(1, 32'h200, 32'h22, 0, 0, 0);
    check("youngest_stalls", last_stalls, FWD ? 0 : 2);
    idle(3);

    // Fill the buffer under continuous loads; fifth store stalls one cycle.
    for (int i = 0; i < 4; i++) begin
      op(1, 32'h500 + 32'(4 * i), 32'h0, 1, 32'h400 + 32'(4 * i), 32'(i + 1));
      check("fill_stalls", last_stalls, 0);
    end
    op(1, 32'h510, 32'h0, 1, 32'h410, 32'h5);
    check("full_stalls", last_stalls, 1);
    check("full_not_empty", bus.wbuf_empty, 0);
    idle(5);
    check("full_drained", bus.wbuf_empty, 1);

    // Loads keep the port; two pending stores drain in the first idle cycles.
    op(1, 32'h700, 32'h0, 1, 32'h600, 32'hA1);
    op(1, 32'h704, 32'h0, 1, 32'h604, 32'hA2);
    op(1, 32'h708, 32'h0, 0, 0, 0);
    op(1, 32'h70C, 32'h0, 0, 0, 0);
    op(1, 32'h710, 32'h0, 0, 0, 0);
    check("load_takes_port", last_rd_port, 1);
    check("pend_after_loads", bus.wbuf_empty, 0);
    idle(1);
    check("pend_idle1", bus.wbuf_empty, 0);
    idle(1);
    check("empty_idle2", bus.wbuf_empty, 1);
    op(1, 32'h600, 32'hA1, 0, 0, 0);
    op(1, 32'h604, 32'hA2, 0, 0, 0);
    idle(2);

    // Reset with three stores pending discards them.
    op(1, 32'h900, 32'h0, 1, 32'h800, 32'hB1);
    op(1, 32'h904, 32'h0, 1, 32'h804, 32'hB2);
    op(1, 32'h908, 32'h0, 1, 32'h808, 32'hB3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wbuf_empty", bus.wbuf_empty, 1);
    check("midrst_sram_en",    bus.sram_en,    0);
    check("midrst_sram_we",    bus.sram_we,    0);
    check("midrst_core_stall", bus.core_stall, 0);
    wr_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("postrst_empty", bus.wbuf_empty, 1);
    op(1, 32'h800, 32'h0, 0, 0, 0);
    op(1, 32'h808, 32'h0, 0, 0, 0);
    idle(2);

    // Pointer wrap: ten stores interleaved with loads, then read them back.
    for (int i = 0; i < 10; i++)
      op(1, 32'hB00 + 32'(4 * i), 32'h0, 1, 32'hA00 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    for (int i = 0; i < 10; i++)
      op(1, 32'hA00 + 32'(4 * i), 32'hC000_0000 + 32'(i), 0, 0, 0);
    idle(6);

    // Same-cycle load and store to one word: the load sees the old value.
    op(0, 0, 0, 1, 32'hC00, 32'h55);
    idle(2);
    op(1, 32'hC00, 32'h55, 1, 32'hC00, 32'h66);
    check("same_cycle_stalls", last_stalls, 0);
    op(1, 32'hC00, 32'h66, 0, 0, 0);
    idle(8);

    check("rd_queue_drained", rd_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
